// File: rtl/data_sram_responder.sv
// Slave end of the CPU data-SRAM port: word-addressed RAM plus an MMIO window
// holding LED, switch, timer, compare/match and RAM-write-counter registers.
module data_sram_responder #(
    parameter int unsigned AW        = 16,
    parameter logic [15:0] MMIO_BASE = 16'hbfaf,
    parameter int unsigned SW_W      = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            data_sram_we,
    input  logic [31:0]     data_sram_addr,
    input  logic [31:0]     data_sram_wdata,
    output logic [31:0]     data_sram_rdata,
    input  logic [SW_W-1:0] switch_i,
    output logic [15:0]     led_o,
    output logic            match_o
);

    localparam logic [15:0] OFF_LED    = 16'h0000;
    localparam logic [15:0] OFF_SWITCH = 16'h0004;
    localparam logic [15:0] OFF_TIMER  = 16'h0008;
    localparam logic [15:0] OFF_CMP    = 16'h000C;
    localparam logic [15:0] OFF_STATUS = 16'h0010;
    localparam logic [15:0] OFF_WRCNT  = 16'h0014;

    logic [31:0]     r_mem [0:(1 << AW) - 1];
    logic [15:0]     r_led;
    logic [SW_W-1:0] r_sw_meta;
    logic [SW_W-1:0] r_sw_sync;
    logic [31:0]     r_timer;
    logic [31:0]     r_cmp;
    logic [31:0]     r_wrcnt;
    logic            r_match;

    logic            w_mmio;
    logic [AW-1:0]   w_idx;
    logic [15:0]     w_off;
    logic            w_ram_we;
    logic            w_mmio_we;
    logic            w_wr_led;
    logic            w_wr_timer;
    logic            w_wr_cmp;
    logic            w_wr_status;
    logic            w_unused;

    assign w_mmio      = (data_sram_addr[31:16] == MMIO_BASE);
    assign w_idx       = data_sram_addr[AW+1:2];
    assign w_off       = data_sram_addr[15:0];
    assign w_ram_we    = data_sram_we & ~w_mmio & ~reset;
    assign w_mmio_we   = data_sram_we & w_mmio;
    assign w_wr_led    = w_mmio_we & (w_off == OFF_LED);
    assign w_wr_timer  = w_mmio_we & (w_off == OFF_TIMER);
    assign w_wr_cmp    = w_mmio_we & (w_off == OFF_CMP);
    assign w_wr_status = w_mmio_we & (w_off == OFF_STATUS);
    assign w_unused    = ^data_sram_addr[1:0];

    // RAM has no reset: contents survive a mid-run reset
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_idx] <= data_sram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led     <= '0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_timer   <= '0;
            r_cmp     <= '1;
            r_wrcnt   <= '0;
            r_match   <= 1'b0;
        end else begin
            r_sw_meta <= switch_i;
            r_sw_sync <= r_sw_meta;
            if (w_wr_led) begin
                r_led <= data_sram_wdata[15:0];
            end
            if (w_wr_timer) begin
                r_timer <= data_sram_wdata;
            end else begin
                r_timer <= r_timer + 32'd1;
            end
            if (w_wr_cmp) begin
                r_cmp <= data_sram_wdata;
            end
            // a match on the same edge as a W1C keeps the flag set
            if (r_timer == r_cmp) begin
                r_match <= 1'b1;
            end else if (w_wr_status && data_sram_wdata[0]) begin
                r_match <= 1'b0;
            end
            if (w_ram_we && (r_wrcnt != '1)) begin
                r_wrcnt <= r_wrcnt + 32'd1;
            end
        end
    end

    always_comb begin
        data_sram_rdata = '0;
        if (w_mmio) begin
            case (w_off)
                OFF_LED:    data_sram_rdata = {16'b0, r_led};
                OFF_SWITCH: data_sram_rdata = 32'(r_sw_sync);
                OFF_TIMER:  data_sram_rdata = r_timer;
                OFF_CMP:    data_sram_rdata = r_cmp;
                OFF_STATUS: data_sram_rdata = {31'b0, r_match};
                OFF_WRCNT:  data_sram_rdata = r_wrcnt;
                default:    data_sram_rdata = '0;
            endcase
        end else begin
            data_sram_rdata = r_mem[w_idx];
        end
    end

    assign led_o   = r_led;
    assign match_o = r_match;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: expected read data is queued when
// each access is driven and popped when the combinational read is sampled.
module tb_data_sram_responder;

    localparam logic [31:0] A_LED    = 32'hbfaf0000;
    localparam logic [31:0] A_SWITCH = 32'hbfaf0004;
    localparam logic [31:0] A_TIMER  = 32'hbfaf0008;
    localparam logic [31:0] A_CMP    = 32'hbfaf000C;
    localparam logic [31:0] A_STATUS = 32'hbfaf0010;
    localparam logic [31:0] A_WRCNT  = 32'hbfaf0014;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  sw;
    logic [15:0] led;
    logic        match;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [31:0] exp_q [$];
    logic [31:0] e;

    data_sram_responder #(.AW(16), .MMIO_BASE(16'hbfaf), .SW_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_we    (we),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .switch_i        (sw),
        .led_o           (led),
        .match_o         (match)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic rst, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        reset = rst;
        we    = w;
        addr  = a;
        wdata = d;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, '0, '0);
        drive(1'b1, 1'b0, '0, '0);
        exp_q.push_back(32'h0);
        drive(1'b0, 1'b0, A_TIMER, '0);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL rst_timer got=%h exp=%h", rdata, e); end
        checks++;
        if (led !== 16'h0) begin failures++; $display("FAIL rst_led got=%h exp=0000", led); end
        checks++;
        if (match !== 1'b0) begin failures++; $display("FAIL rst_match got=%b exp=0", match); end
        exp_q.push_back(32'hffffffff);
        drive(1'b0, 1'b0, A_CMP, '0);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL rst_cmp got=%h exp=%h", rdata, e); end
        exp_q.push_back(32'h0);
        drive(1'b0, 1'b0, A_WRCNT, '0);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL rst_wrcnt got=%h exp=%h", rdata, e); end
        exp_q.push_back(32'h0);
        drive(1'b0, 1'b0, A_STATUS, '0);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL rst_status got=%h exp=%h", rdata, e); end
    endtask

    task automatic test_ram();
        drive(1'b0, 1'b1, 32'h1c000014, 32'h5555aaaa);
        drive(1'b0, 1'b1, 32'h1c000010, 32'hdeadbeef);
        exp_q.push_back(32'hdeadbeef);
        drive(1'b0, 1'b0, 32'h1c000010, '0);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL ram_ld got=%h exp=%h", rdata, e); end
        exp_q.push_back(32'h5555aaaa);
        drive(1'b0, 1'b0, 32'h1c000014, '0);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL ram_neighbour got=%h exp=%h", rdata, e); end
        exp_q.push_back(32'hdeadbeef);
        drive(1'b0, 1'b0, 32'h1c040013, '0);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL ram_alias got=%h exp=%h", rdata, e); end
        exp_q.push_back(32'd2);
        drive(1'b0, 1'b0, A_WRCNT, '0);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL ram_wrcnt2 got=%h exp=%h", rdata, e); end
        exp_q.push_back(32'hdeadbeef);
        drive(1'b0, 1'b1, 32'h1c000010, 32'hcafef00d);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL ram_old_in_wr got=%h exp=%h", rdata, e); end
        exp_q.push_back(32'hcafef00d);
        drive(1'b0, 1'b0, 32'h1c000010, '0);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL ram_overwrite got=%h exp=%h", rdata, e); end
        exp_q.push_back(32'd3);
        drive(1'b0, 1'b0, A_WRCNT, '0);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL ram_wrcnt3 got=%h exp=%h", rdata, e); end
    endtask

    task automatic test_led();
        drive(1'b0, 1'b1, A_LED, 32'h0001a5a5);
        exp_q.push_back(32'h0000a5a5);
        drive(1'b0, 1'b0, A_LED, '0);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL led_rd got=%h exp=%h", rdata, e); end
        checks++;
        if (led !== 16'ha5a5) begin failures++; $display("FAIL led_o got=%h exp=a5a5", led); end
        exp_q.push_back(32'd3);
        drive(1'b0, 1'b0, A_WRCNT, '0);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL led_wrcnt got=%h exp=%h", rdata, e); end
    endtask

    task automatic test_timer_wrap();
        drive(1'b0, 1'b1, A_TIMER, 32'hfffffffe);
        exp_q.push_back(32'hfffffffe);
        exp_q.push_back(32'hffffffff);
        exp_q.push_back(32'h00000000);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, A_TIMER, '0);
            e = exp_q.pop_front(); checks++;
            if (rdata !== e) begin failures++; $display("FAIL timer_wrap%0d got=%h exp=%h", i, rdata, e); end
        end
    endtask

    task automatic test_match();
        logic [31:0] t;
        drive(1'b0, 1'b1, A_CMP, 32'd10);
        drive(1'b0, 1'b1, A_TIMER, 32'd5);
        drive(1'b0, 1'b1, A_STATUS, 32'h1);
        t = 32'd6;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(t);
            drive(1'b0, 1'b0, A_TIMER, '0);
            e = exp_q.pop_front(); checks++;
            if (rdata !== e) begin failures++; $display("FAIL match_timer%0d got=%h exp=%h", i, rdata, e); end
            checks++;
            if (match !== 1'b0) begin failures++; $display("FAIL match_early%0d got=%b exp=0", i, match); end
            t = t + 32'd1;
        end
        exp_q.push_back(32'h1);
        drive(1'b0, 1'b0, A_STATUS, '0);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL match_status got=%h exp=%h", rdata, e); end
        checks++;
        if (match !== 1'b1) begin failures++; $display("FAIL match_rise got=%b exp=1", match); end
        drive(1'b0, 1'b1, A_STATUS, 32'h1);
        exp_q.push_back(32'h0);
        drive(1'b0, 1'b0, A_STATUS, '0);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL w1c_status got=%h exp=%h", rdata, e); end
        checks++;
        if (match !== 1'b0) begin failures++; $display("FAIL w1c_match got=%b exp=0", match); end
        drive(1'b0, 1'b1, A_TIMER, 32'd8);
        exp_q.push_back(32'd8);
        exp_q.push_back(32'd9);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, A_TIMER, '0);
            e = exp_q.pop_front(); checks++;
            if (rdata !== e) begin failures++; $display("FAIL race_timer%0d got=%h exp=%h", i, rdata, e); end
        end
        drive(1'b0, 1'b1, A_STATUS, 32'h1);
        exp_q.push_back(32'h1);
        drive(1'b0, 1'b0, A_STATUS, '0);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL race_status got=%h exp=%h", rdata, e); end
        checks++;
        if (match !== 1'b1) begin failures++; $display("FAIL race_match got=%b exp=1", match); end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, A_LED, 32'h0000ffff);
        drive(1'b0, 1'b0, A_LED, '0);
        checks++;
        if (led !== 16'hffff) begin failures++; $display("FAIL mid_led_pre got=%h exp=ffff", led); end
        drive(1'b1, 1'b1, 32'h1c000010, 32'h12345678);
        exp_q.push_back(32'h0);
        drive(1'b0, 1'b0, A_TIMER, '0);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL mid_timer got=%h exp=%h", rdata, e); end
        checks++;
        if (led !== 16'h0) begin failures++; $display("FAIL mid_led got=%h exp=0000", led); end
        checks++;
        if (match !== 1'b0) begin failures++; $display("FAIL mid_match got=%b exp=0", match); end
        exp_q.push_back(32'hffffffff);
        drive(1'b0, 1'b0, A_CMP, '0);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL mid_cmp got=%h exp=%h", rdata, e); end
        exp_q.push_back(32'h0);
        drive(1'b0, 1'b0, A_WRCNT, '0);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL mid_wrcnt got=%h exp=%h", rdata, e); end
        exp_q.push_back(32'hcafef00d);
        drive(1'b0, 1'b0, 32'h1c000010, '0);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL mid_ram_kept got=%h exp=%h", rdata, e); end
    endtask

    task automatic test_switch();
        exp_q.push_back(32'h0);
        drive(1'b0, 1'b0, A_SWITCH, '0);
        sw = 8'h5a;
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL sw_edge0 got=%h exp=%h", rdata, e); end
        exp_q.push_back(32'h0);
        drive(1'b0, 1'b0, A_SWITCH, '0);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL sw_edge1 got=%h exp=%h", rdata, e); end
        exp_q.push_back(32'h0000005a);
        drive(1'b0, 1'b0, A_SWITCH, '0);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL sw_edge2 got=%h exp=%h", rdata, e); end
        exp_q.push_back(32'h0);
        drive(1'b0, 1'b1, 32'hbfaf0100, 32'hffffffff);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL unmapped got=%h exp=%h", rdata, e); end
        exp_q.push_back(32'h0);
        drive(1'b0, 1'b0, A_WRCNT, '0);
        e = exp_q.pop_front(); checks++;
        if (rdata !== e) begin failures++; $display("FAIL unmapped_wrcnt got=%h exp=%h", rdata, e); end
    endtask

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        sw    = '0;
        test_reset();
        test_ram();
        test_led();
        test_timer_wrap();
        test_match();
        test_reset_mid();
        test_switch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
